// File: rtl/hud_stat_writer_if.sv
// Hit/clear inputs and HUD digit-write outputs of hud_stat_writer.
// The master side drives hits; the slave side is the writer itself.
interface hud_stat_writer_if;
    logic       hit_valid;
    logic [2:0] hit_drum;
    logic       clear_all;
    logic       write;
    logic [3:0] num;
    logic [3:0] blob;
    logic       busy;

    modport master (
        output hit_valid, hit_drum, clear_all,
        input  write, num, blob, busy
    );

    modport slave (
        input  hit_valid, hit_drum, clear_all,
        output write, num, blob, busy
    );
endinterface

// File: rtl/hud_stat_writer.sv
// Per-drum two-digit BCD hit counters, repainted onto the HUD digit store one drum at a time.
// Define HUD_STAT_SATURATE_EN to hold counters at 99 instead of wrapping to 00.
module hud_stat_writer #(
    parameter int unsigned NUM_DRUMS = 8,
    parameter int unsigned WRITE_GAP = 1
) (
    input  logic             vclock,
    input  logic             reset_n,
    hud_stat_writer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StWrTens,
        StGap1,
        StWrOnes,
        StGap2
    } state_e;

    localparam logic [3:0] GAP_LAST  = (WRITE_GAP == 0) ? 4'd0 : 4'(WRITE_GAP - 1);
    localparam logic [3:0] DRUMS_W   = 4'(NUM_DRUMS);
    localparam logic [2:0] LAST_DRUM = 3'(NUM_DRUMS - 1);

    state_e               r_state, w_state_d;
    logic [3:0]           r_gap, w_gap_d;
    logic [3:0]           r_tens [NUM_DRUMS];
    logic [3:0]           r_ones [NUM_DRUMS];
    logic [NUM_DRUMS-1:0] r_pend, w_pend_d;
    logic [2:0]           r_last;
    logic [2:0]           w_sel;
    logic                 w_found;
    int unsigned          w_k;
    logic [3:0]           w_sel_tens, w_sel_ones;
    logic [3:0]           r_snap_tens, r_snap_ones;
    logic [2:0]           r_snap_drum;
    logic                 r_write;
    logic [3:0]           r_num, r_blob;
    logic                 w_hit_ok;

    assign w_hit_ok = bus.hit_valid && ({1'b0, bus.hit_drum} < DRUMS_W);

    function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (ones != 4'd9) begin
            res = {tens, ones + 4'd1};
        end else if (tens != 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
`ifdef HUD_STAT_SATURATE_EN
            res = {tens, ones};
`else
            res = 8'h00;
`endif
        end
        return res;
    endfunction

    // Round-robin: first pending drum strictly after the last-served one.
    always_comb begin
        w_sel      = r_last;
        w_found    = 1'b0;
        w_k        = 0;
        w_sel_tens = 4'd0;
        w_sel_ones = 4'd0;
        for (int unsigned i = 1; i <= NUM_DRUMS; i++) begin
            w_k = 32'(r_last) + i;
            if (w_k >= NUM_DRUMS) w_k = w_k - NUM_DRUMS;
            for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
                if (!w_found && (w_k == d) && r_pend[d]) begin
                    w_found = 1'b1;
                    w_sel   = 3'(d);
                end
            end
        end
        for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
            if (w_sel == 3'(d)) begin
                w_sel_tens = r_tens[d];
                w_sel_ones = r_ones[d];
            end
        end
    end

    // A hit in the latch cycle re-arms the drum just latched; clear_all overrides everything.
    always_comb begin
        w_pend_d = r_pend;
        if (r_state == StLatch) begin
            for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
                if (w_sel == 3'(d)) w_pend_d[d] = 1'b0;
            end
        end
        if (w_hit_ok) begin
            for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
                if (bus.hit_drum == 3'(d)) w_pend_d[d] = 1'b1;
            end
        end
        if (bus.clear_all) w_pend_d = '1;
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '1;
            for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
                r_tens[d] <= 4'd0;
                r_ones[d] <= 4'd0;
            end
        end else begin
            r_pend <= w_pend_d;
            for (int unsigned d = 0; d < NUM_DRUMS; d++) begin
                if (bus.clear_all) begin
                    r_tens[d] <= 4'd0;
                    r_ones[d] <= 4'd0;
                end else if (w_hit_ok && (bus.hit_drum == 3'(d))) begin
                    {r_tens[d], r_ones[d]} <= bcd_inc(r_tens[d], r_ones[d]);
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_gap_d   = 4'd0;
        unique case (r_state)
            StIdle:   if (|r_pend) w_state_d = StLatch;
            StLatch:  w_state_d = StWrTens;
            StWrTens: w_state_d = (WRITE_GAP == 0) ? StWrOnes : StGap1;
            StGap1: begin
                if (r_gap == GAP_LAST) w_state_d = StWrOnes;
                else                   w_gap_d   = r_gap + 4'd1;
            end
            StWrOnes: w_state_d = (WRITE_GAP == 0) ? StIdle : StGap2;
            StGap2: begin
                if (r_gap == GAP_LAST) w_state_d = StIdle;
                else                   w_gap_d   = r_gap + 4'd1;
            end
            default:  w_state_d = StIdle;
        endcase
    end

    // Outputs are registered, so each strobe trails its write state by one cycle.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_gap       <= 4'd0;
            r_last      <= LAST_DRUM;
            r_snap_drum <= 3'd0;
            r_snap_tens <= 4'd0;
            r_snap_ones <= 4'd0;
            r_write     <= 1'b0;
            r_num       <= 4'd0;
            r_blob      <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_gap   <= w_gap_d;
            if (r_state == StLatch) begin
                r_snap_drum <= w_sel;
                r_last      <= w_sel;
                r_snap_tens <= w_sel_tens;
                r_snap_ones <= w_sel_ones;
            end
            r_write <= (r_state == StWrTens) || (r_state == StWrOnes);
            if (r_state == StWrTens) begin
                r_num  <= r_snap_tens;
                r_blob <= {r_snap_drum, 1'b0};
            end else if (r_state == StWrOnes) begin
                r_num  <= r_snap_ones;
                r_blob <= {r_snap_drum, 1'b1};
            end
        end
    end

    assign bus.write = r_write;
    assign bus.num   = r_num;
    assign bus.blob  = r_blob;
    assign bus.busy  = (r_state != StIdle) || (|r_pend);

endmodule
